pipeline_chain: RTL and testbench

PIPELINE_CHAIN -- requirements
Module: pipeline_chain

---
 rtl/pipeline_chain_pkg.sv | 19 +
 rtl/pipeline_stage.sv | 58 +++++
 rtl/pipeline_chain.sv | 112 +++++++++++
 tb/tb_pipeline_chain.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_chain_pkg.sv
// Shared constants and helpers for the pipeline_chain block.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   DEFAULT_WIDTH  - default payload width per stage
//   DEFAULT_STAGES - default number of register stages
//   occ_width()    - bits needed to count 0..stages valid entries
package pipeline_chain_pkg;

  localparam int DEFAULT_WIDTH  = 32;
  localparam int DEFAULT_STAGES = 4;

  // Occupancy must represent every value from 0 to stages inclusive.
  function automatic int occ_width(input int stages);
    return $clog2(stages + 1);
  endfunction

endpackage

// File: rtl/pipeline_stage.sv
// One valid+data register of the chain with flush, hold (via load_i=0) and load.
// Latency: 1 cycle from load to valid_o/data_o.
// Backpressure: none internally; the caller drops load_i to freeze the stage.
//
// Ports:
//   clock, reset      - rising-edge clock, synchronous active-high reset
//   load_i            - stage is ready this cycle: capture valid_i/data_i
//   flush_i           - clear the stage; wins over load_i
//   valid_i, data_i   - incoming entry from the upstream side
//   valid_o, data_o   - registered entry
//   valid_nxt_o       - valid bit the stage will hold after this edge
module pipeline_stage
  import pipeline_chain_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_i,
  input  logic             flush_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_nxt_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush_i) begin
      valid_d = 1'b0;
      data_d  = '0;
    end else if (load_i) begin
      // Bubbles carry zero payload so stale data never lingers in a stage.
      valid_d = valid_i;
      data_d  = valid_i ? data_i : '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o     = valid_q;
  assign data_o      = data_q;
  assign valid_nxt_o = valid_d;

endmodule

// File: rtl/pipeline_chain.sv
// Register pipeline of STAGES valid+data stages with per-stage flush and hold.
// Latency: STAGES cycles from acceptance to out_valid; 1 entry/cycle throughput.
// Backpressure: ready ripples back from out_ready; in_ready is combinational.
//
// Build option: define PIPELINE_CHAIN_COLLAPSE_EN to let empty stages accept
// data behind a stall (bubble collapse). Without it the chain stalls in
// lockstep and bubbles are preserved.
//
// Ports:
//   clock, reset              - rising-edge clock, synchronous active-high reset
//   in_valid/in_data/in_ready - upstream handshake into stage 0
//   flush[i], hold[i]         - per-stage invalidate / freeze
//   out_valid/out_data/out_ready - downstream handshake from the last stage
//   stage_valid, stage_data   - per-stage visibility (stage i at [i*WIDTH +: WIDTH])
//   occupancy                 - registered count of valid stages
module pipeline_chain
  import pipeline_chain_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STAGES = DEFAULT_STAGES
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          in_valid,
  input  logic [WIDTH-1:0]              in_data,
  output logic                          in_ready,
  input  logic [STAGES-1:0]             flush,
  input  logic [STAGES-1:0]             hold,
  output logic                          out_valid,
  output logic [WIDTH-1:0]              out_data,
  input  logic                          out_ready,
  output logic [STAGES-1:0]             stage_valid,
  output logic [STAGES*WIDTH-1:0]       stage_data,
  output logic [occ_width(STAGES)-1:0]  occupancy
);

  localparam int OCC_W = occ_width(STAGES);

  logic [STAGES:0]       ready;
  logic [STAGES-1:0]     valid_vec;
  logic [STAGES-1:0]     valid_nxt;
  logic [STAGES*WIDTH-1:0] data_vec;
  logic [OCC_W-1:0]      occ_q, occ_d;

  // ready[i] means stage i may take a new entry this cycle.
  always_comb begin
    ready         = '0;
    ready[STAGES] = out_ready;
    for (int i = STAGES - 1; i >= 0; i--) begin
`ifdef PIPELINE_CHAIN_COLLAPSE_EN
      ready[i] = !hold[i] && (!valid_vec[i] || ready[i+1]);
`else
      ready[i] = !hold[i] && ready[i+1];
`endif
    end
  end

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    logic             up_valid;
    logic [WIDTH-1:0] up_data;

    if (g == 0) begin : g_head
      assign up_valid = in_valid;
      assign up_data  = in_data;
    end else begin : g_body
      // The upstream entry only moves forward when its stage lets go of it:
      // either it advances normally or it is being flushed out of that stage.
      // A held, unflushed upstream entry sends a bubble instead of a copy.
      assign up_valid = valid_vec[g-1] && (ready[g-1] || flush[g-1]);
      assign up_data  = data_vec[(g-1)*WIDTH +: WIDTH];
    end

    pipeline_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clock       (clock),
      .reset       (reset),
      .load_i      (ready[g]),
      .flush_i     (flush[g]),
      .valid_i     (up_valid),
      .data_i      (up_data),
      .valid_o     (valid_vec[g]),
      .data_o      (data_vec[g*WIDTH +: WIDTH]),
      .valid_nxt_o (valid_nxt[g])
    );
  end

  // Occupancy is registered from the next-state valid bits so it always
  // matches stage_valid after each edge.
  always_comb begin
    occ_d = '0;
    for (int i = 0; i < STAGES; i++) begin
      occ_d = occ_d + OCC_W'(valid_nxt[i]);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign in_ready    = ready[0];
  assign out_valid   = valid_vec[STAGES-1];
  assign out_data    = data_vec[(STAGES-1)*WIDTH +: WIDTH];
  assign stage_valid = valid_vec;
  assign stage_data  = data_vec;
  assign occupancy   = occ_q;

endmodule

// File: tb/tb_pipeline_chain.sv
// Directed bench for pipeline_chain with STAGES=4, WIDTH=16.
// Expected values are hand-derived per phase; both build variants of the
// chain (with and without PIPELINE_CHAIN_COLLAPSE_EN) are covered.
module tb_pipeline_chain;

  localparam int W = 16;
  localparam int S = 4;

  logic           clock = 1'b0;
  logic           reset;
  logic           in_valid;
  logic [W-1:0]   in_data;
  logic           in_ready;
  logic [S-1:0]   flush;
  logic [S-1:0]   hold;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic           out_ready;
  logic [S-1:0]   stage_valid;
  logic [S*W-1:0] stage_data;
  logic [2:0]     occupancy;

  int n_checks = 0;
  int n_fail   = 0;

  pipeline_chain #(
    .WIDTH  (W),
    .STAGES (S)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .flush       (flush),
    .hold        (hold),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .stage_valid (stage_valid),
    .stage_data  (stage_data),
    .occupancy   (occupancy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  logic [S-1:0]   ev;
  logic [S*W-1:0] ed;
  int             eo;

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    flush     = '0;
    hold      = '0;
    tick();
    tick();

    // Reset state
    chk("rst_stage_valid", 64'(stage_valid), 64'h0);
    chk("rst_occupancy",   64'(occupancy),   64'h0);
    chk("rst_out_valid",   64'(out_valid),   64'h0);
    chk("rst_stage_data",  64'(stage_data),  64'h0);

    // Stream 1..8 with no stalls; invalid cycles drive junk data
    reset     = 1'b0;
    out_ready = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      in_valid = (c <= 8);
      in_data  = (c <= 8) ? 16'(c) : 16'hBEEF;
      #1;
      chk("strm_in_ready", 64'(in_ready), 64'h1);
      tick();
      ev = '0;
      ed = '0;
      eo = 0;
      for (int j = 0; j < S; j++) begin
        if ((c - j) >= 1 && (c - j) <= 8) begin
          ev[j]          = 1'b1;
          ed[j*W +: W]   = 16'(c - j);
          eo++;
        end
      end
      chk("strm_stage_valid", 64'(stage_valid), 64'(ev));
      chk("strm_stage_data",  64'(stage_data),  64'(ed));
      chk("strm_occupancy",   64'(occupancy),   64'(eo));
      chk("strm_out_valid",   64'(out_valid),   64'(ev[S-1]));
      if (c >= 4 && c <= 11) chk("strm_out_data", 64'(out_data), 64'(c - 3));
    end

    // Single entry parked in stage 3, then downstream stalls
    in_valid = 1'b1;
    in_data  = 16'h0001;
    tick();
    in_valid = 1'b0;
    in_data  = 16'hDEAD;
    tick();
    tick();
    tick();
    chk("park_stage_valid", 64'(stage_valid), 64'h8);
    chk("park_out_data",    64'(out_data),    64'h1);
    out_ready = 1'b0;
    #1;
`ifdef PIPELINE_CHAIN_COLLAPSE_EN
    chk("stall_in_ready", 64'(in_ready), 64'h1);
`else
    chk("stall_in_ready", 64'(in_ready), 64'h0);
`endif
    for (int k = 2; k <= 4; k++) begin
      in_valid = 1'b1;
      in_data  = 16'(k);
      tick();
`ifdef PIPELINE_CHAIN_COLLAPSE_EN
      ev = (k == 2) ? 4'b1001 : (k == 3) ? 4'b1011 : 4'b1111;
      eo = k;
`else
      ev = 4'b1000;
      eo = 1;
`endif
      chk("stall_stage_valid", 64'(stage_valid), 64'(ev));
      chk("stall_occupancy",   64'(occupancy),   64'(eo));
    end
    in_data = 16'h0005;
    #1;
    chk("stall_full_in_ready", 64'(in_ready), 64'h0);
    chk("stall_head_data",     64'(out_data), 64'h1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
`ifdef PIPELINE_CHAIN_COLLAPSE_EN
    chk("release_out_valid", 64'(out_valid), 64'h1);
    chk("release_out_data",  64'(out_data),  64'h2);
`else
    chk("release_out_valid", 64'(out_valid), 64'h0);
`endif
    for (int k = 0; k < 4; k++) tick();
    chk("release_drained", 64'(occupancy), 64'h0);

    // Fill four entries, then flush stages 0 and 1 with downstream stalled
    for (int k = 1; k <= 4; k++) begin
      in_valid = 1'b1;
      in_data  = 16'(k * 16'h11);
      tick();
    end
    chk("fill_stage_data", 64'(stage_data), 64'h0011_0022_0033_0044);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 4'b0011;
    tick();
    flush = '0;
    chk("flush_stage_valid", 64'(stage_valid), 64'hC);
    chk("flush_occupancy",   64'(occupancy),   64'h2);
    chk("flush_stage_data",  64'(stage_data),  64'h0011_0022_0000_0000);
    out_ready = 1'b1;
    tick();
    chk("flush_next_out", 64'(out_data), 64'h22);
    tick();
    tick();
    tick();
    chk("flush_drained", 64'(occupancy), 64'h0);

    // Hold stage 2 for three cycles while input streams
    in_valid = 1'b1;
    in_data  = 16'h0101;
    tick();
    in_data  = 16'h0102;
    tick();
    in_valid = 1'b0;
    in_data  = 16'hDEAD;
    tick();
    tick();
    chk("hold_pre_valid", 64'(stage_valid), 64'hC);
    hold = 4'b0100;
    for (int k = 1; k <= 3; k++) begin
      in_valid = 1'b1;
      in_data  = 16'(16'h0102 + k);
      #1;
`ifdef PIPELINE_CHAIN_COLLAPSE_EN
      chk("hold_in_ready", 64'(in_ready), 64'(k < 3));
`else
      chk("hold_in_ready", 64'(in_ready), 64'h0);
`endif
      tick();
`ifdef PIPELINE_CHAIN_COLLAPSE_EN
      ev = (k == 1) ? 4'b0101 : 4'b0111;
`else
      ev = 4'b0100;
`endif
      chk("hold_stage_valid", 64'(stage_valid), 64'(ev));
      chk("hold_frozen_data", 64'(stage_data[2*W +: W]), 64'h0102);
      chk("hold_out_valid",   64'(out_valid), 64'h0);
    end
`ifdef PIPELINE_CHAIN_COLLAPSE_EN
    chk("hold_fill_data", 64'(stage_data[0 +: 2*W]), 64'h0103_0104);
`endif
    hold     = '0;
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    chk("hold_drained", 64'(occupancy), 64'h0);

    // Reset mid-stream with three entries in flight
    for (int k = 1; k <= 3; k++) begin
      in_valid = 1'b1;
      in_data  = 16'(16'h0200 + k);
      tick();
    end
    chk("mid_occupancy", 64'(occupancy), 64'h3);
    reset   = 1'b1;
    in_data = 16'h0777;
    flush   = 4'b1010;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'h1);
    tick();
    reset    = 1'b0;
    in_valid = 1'b0;
    flush    = '0;
    chk("mid_rst_occupancy",   64'(occupancy),   64'h0);
    chk("mid_rst_out_valid",   64'(out_valid),   64'h0);
    chk("mid_rst_stage_data",  64'(stage_data),  64'h0);
    chk("mid_rst_stage_valid", 64'(stage_valid), 64'h0);
    tick();
    chk("rst_drop_valid", 64'(stage_valid), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
